// File: rtl/multi_gate_accum.sv
// multi_gate_accum: NUM_IN-channel bitwise logic gate with optional frame
// accumulation and valid/ready handshakes on both sides.
module multi_gate_accum #(
  parameter int WIDTH     = 8,
  parameter int NUM_IN    = 4,
  parameter int FRAME_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_IN*WIDTH-1:0]     in_data,
  input  logic [2:0]                  op,
  input  logic                        accum_en,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [$clog2(FRAME_LEN+1)-1:0] out_count
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_LEN);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);

  typedef enum logic {IDLE, ACCUM} state_t;
  typedef enum logic [1:0] {BASE_AND, BASE_OR, BASE_XOR} base_t;

  function automatic logic [WIDTH-1:0] apply_base(input base_t b,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
    case (b)
      BASE_AND: apply_base = x & y;
      BASE_XOR: apply_base = x ^ y;
      default:  apply_base = x | y;
    endcase
  endfunction

  state_t            state_q, state_d;
  base_t             base_q, base_d;
  logic              inv_q, inv_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic [CW-1:0]     out_count_q, out_count_d;

  base_t             cur_base, sel_base;
  logic              cur_inv;
  logic [WIDTH-1:0]  red;
  logic              accept;
  logic              emit;
  logic [WIDTH-1:0]  emit_data;
  logic [CW-1:0]     emit_cnt;
  logic [WIDTH-1:0]  fold_acc;
  logic [CW-1:0]     fold_cnt;

  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

  // Decode the live op into a base reduction and an emit-time invert flag.
  always_comb begin
    cur_base = BASE_OR;
    cur_inv  = 1'b0;
    case (op)
      3'b000: cur_base = BASE_AND;
      3'b001: cur_base = BASE_OR;
      3'b010: cur_base = BASE_XOR;
      3'b011: begin cur_base = BASE_AND; cur_inv = 1'b1; end
      3'b100: begin cur_base = BASE_OR;  cur_inv = 1'b1; end
      3'b101: begin cur_base = BASE_XOR; cur_inv = 1'b1; end
      default: cur_base = BASE_OR;
    endcase
  end

  // Reduce all channels of the current beat; mid-frame the latched op is used.
  always_comb begin
    sel_base = (state_q == ACCUM) ? base_q : cur_base;
    red      = in_data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      red = apply_base(sel_base, red, in_data[k*WIDTH +: WIDTH]);
    end
  end

  // Next-state: frame bookkeeping, flush handling and output register loading.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    inv_d       = inv_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    emit        = 1'b0;
    emit_data   = '0;
    emit_cnt    = '0;
    fold_acc    = acc_q;
    fold_cnt    = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!accum_en || FRAME_LEN == 1) begin
            emit      = 1'b1;
            emit_data = cur_inv ? ~red : red;
            emit_cnt  = ONE_CNT;
          end else begin
            state_d = ACCUM;
            base_d  = cur_base;
            inv_d   = cur_inv;
            acc_d   = red;
            cnt_d   = ONE_CNT;
          end
        end
      end
      ACCUM: begin
        // Flush waits for a free output slot; a coincident beat is folded first.
        if (in_ready) begin
          if (accept) begin
            fold_acc = apply_base(base_q, acc_q, red);
            fold_cnt = cnt_q + ONE_CNT;
          end
          if (fold_cnt == FRAME_CNT || flush) begin
            emit      = 1'b1;
            emit_data = inv_q ? ~fold_acc : fold_acc;
            emit_cnt  = fold_cnt;
            acc_d     = '0;
            cnt_d     = '0;
            state_d   = IDLE;
          end else begin
            acc_d = fold_acc;
            cnt_d = fold_cnt;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      out_valid_d = 1'b1;
      out_data_d  = emit_data;
      out_count_d = emit_cnt;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= BASE_AND;
      inv_q       <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      inv_q       <= inv_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

endmodule

// File: tb/tb_multi_gate_accum.sv
// tb_multi_gate_accum: directed plan steps followed by random traffic, all
// checked against a frame-level reference model held in the bench.
module tb_multi_gate_accum;

  localparam int W   = 8;
  localparam int NI  = 4;
  localparam int FL  = 4;
  localparam int CW  = $clog2(FL + 1);
  localparam int DW  = NI * W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [2:0]    op = '0;
  logic          accum_en = 1'b0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;

  multi_gate_accum #(.WIDTH(W), .NUM_IN(NI), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .op(op), .accum_en(accum_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the beats of the open frame are kept verbatim and the
  // result is computed from them only when the frame is emitted.
  logic [DW-1:0] frame_q[$];
  bit            known = 0;
  bit            busy  = 0;
  logic [2:0]    fop   = '0;
  bit            mv    = 0;
  logic [W-1:0]  md    = '0;
  int            mc    = 0;

  function automatic logic [W-1:0] eval_frame(input logic [2:0] o);
    logic [W-1:0]  r;
    logic [W-1:0]  ch;
    logic [DW-1:0] beat;
    r = (o == 3'd0 || o == 3'd3) ? '1 : '0;
    foreach (frame_q[b]) begin
      beat = frame_q[b];
      for (int k = 0; k < NI; k++) begin
        ch = beat[k*W +: W];
        case (o)
          3'd0, 3'd3: r = r & ch;
          3'd2, 3'd5: r = r ^ ch;
          default:    r = r | ch;
        endcase
      end
    end
    if (o == 3'd3 || o == 3'd4 || o == 3'd5) r = ~r;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model,
  // then return just after the posedge so callers can inspect new outputs.
  task automatic cycle(input bit r, input bit iv, input logic [DW-1:0] d,
                       input logic [2:0] o, input bit ae, input bit fl, input bit ordy);
    bit rdy;
    bit acc;
    bit emit;
    logic [2:0] eop;
    @(negedge clk);
    rst = r; in_valid = iv; in_data = d; op = o; accum_en = ae; flush = fl; out_ready = ordy;
    #1;
    if (known) begin
      check("out_valid", 32'(out_valid), 32'(mv));
      check("out_count", 32'(out_count), 32'(mc));
      check("in_ready", 32'(in_ready), 32'(!mv || ordy));
      if (mv || mc == 0) check("out_data", 32'(out_data), 32'(md));
    end
    if (r) begin
      known = 1; busy = 0; mv = 0; md = '0; mc = 0; frame_q.delete();
    end else begin
      rdy  = !mv || ordy;
      acc  = iv && rdy;
      emit = 0;
      eop  = o;
      if (!busy) begin
        if (acc) begin
          frame_q.delete();
          frame_q.push_back(d);
          if (!ae || FL == 1) begin
            emit = 1;
          end else begin
            busy = 1;
            fop  = o;
          end
        end
      end else if (rdy) begin
        if (acc) frame_q.push_back(d);
        if (frame_q.size() == FL || fl) begin
          emit = 1;
          eop  = fop;
          busy = 0;
        end
      end
      if (emit) begin
        md = eval_frame(eop);
        mc = frame_q.size();
        frame_q.delete();
        mv = 1;
      end else if (mv && ordy) begin
        mv = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1. Reset then pass-mode OR
    cycle(1, 0, '0, 3'd0, 0, 0, 1);
    cycle(1, 0, '0, 3'd0, 0, 0, 1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    cycle(0, 1, 32'h08040201, 3'b001, 0, 0, 1);
    check("or_valid", 32'(out_valid), 32'd1);
    check("or_data", 32'(out_data), 32'h0F);
    check("or_count", 32'(out_count), 32'd1);

    // 2. NAND pass, reserved op acts as OR
    cycle(0, 1, 32'hF0FFFFFF, 3'b011, 0, 0, 1);
    check("nand_data", 32'(out_data), 32'h0F);
    check("nand_count", 32'(out_count), 32'd1);
    cycle(0, 1, 32'h00000201, 3'b111, 0, 0, 1);
    check("rsv_data", 32'(out_data), 32'h03);

    // 3. XOR frame, op changes mid-frame are ignored
    cycle(0, 1, 32'h00000001, 3'b010, 1, 0, 1);
    check("xor_b1_valid", 32'(out_valid), 32'd0);
    cycle(0, 1, 32'h00000002, 3'b000, 1, 0, 1);
    check("xor_b2_valid", 32'(out_valid), 32'd0);
    cycle(0, 1, 32'h00000003, 3'b000, 0, 0, 1);
    check("xor_b3_valid", 32'(out_valid), 32'd0);
    cycle(0, 1, 32'h00000004, 3'b000, 1, 0, 1);
    check("xor_valid", 32'(out_valid), 32'd1);
    check("xor_data", 32'(out_data), 32'h04);
    check("xor_count", 32'(out_count), 32'd4);

    // 4. Backpressure holds output and refuses beats
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 32'h000000FF, 3'b001, 0, 0, 0);
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_data", 32'(out_data), 32'h04);
    end
    cycle(0, 1, 32'h000000AA, 3'b001, 0, 0, 1);
    check("bp_rel_data", 32'(out_data), 32'hAA);
    check("bp_rel_count", 32'(out_count), 32'd1);

    // 5. Flush alone, then flush with a beat
    cycle(0, 1, 32'h00000010, 3'b001, 1, 0, 1);
    cycle(0, 1, 32'h00000020, 3'b001, 1, 0, 1);
    cycle(0, 0, '0, 3'b001, 1, 1, 1);
    check("fl_data", 32'(out_data), 32'h30);
    check("fl_count", 32'(out_count), 32'd2);
    cycle(0, 1, 32'h00000010, 3'b001, 1, 0, 1);
    cycle(0, 1, 32'h00000020, 3'b001, 1, 0, 1);
    cycle(0, 1, 32'h00000040, 3'b001, 1, 1, 1);
    check("flb_data", 32'(out_data), 32'h70);
    check("flb_count", 32'(out_count), 32'd3);

    // 6. Reset mid-frame discards partial beats
    cycle(0, 1, 32'h00000080, 3'b001, 1, 0, 1);
    cycle(0, 1, 32'h00000040, 3'b001, 1, 0, 1);
    cycle(1, 0, '0, 3'b001, 1, 0, 1);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_data", 32'(out_data), 32'd0);
    check("mrst_count", 32'(out_count), 32'd0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 32'h00000001, 3'b001, 1, 0, 1);
    check("mrst_f_data", 32'(out_data), 32'h01);
    check("mrst_f_count", 32'(out_count), 32'd4);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(63) == 0), ($urandom_range(3) != 0), DW'($urandom),
            3'($urandom_range(7)), ($urandom_range(3) != 0),
            ($urandom_range(7) == 0), ($urandom_range(3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_gate_accum.md
Name: multi_gate_accum

Overview:
- Parametrised, registered successor to the single 2-input gate: combines NUM_IN channels of WIDTH bits bitwise with a run-time-selected logic op (AND/OR/XOR/NAND/NOR/XNOR).
- Optionally accumulates results across a frame of FRAME_LEN input beats before emitting one result.
- Valid/ready handshake on both sides; sits between stream producers and consumers in the logic/datapath library.

Parameters:
WIDTH, 8, bit width of each channel and of out_data
NUM_IN, 4, number of input channels (>=2)
FRAME_LEN, 4, beats per accumulation frame (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
in_data  input  NUM_IN*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
op  input  3  000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 11x treated as OR
accum_en  input  1  1 = accumulate a frame, 0 = single-beat pass mode
flush  input  1  level request: emit partial frame
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result
out_count  output  $clog2(FRAME_LEN+1)  beats contributing to out_data

Behaviour:
- Reset (sync, rst=1 at clk edge): out_valid=0, out_data=0, out_count=0, state=IDLE, acc=0, cnt=0. Reset mid-frame discards the partial frame with no emission. in_ready=1 in the cycle after reset.
- Base op: AND for AND/NAND, OR for OR/NOR, XOR for XOR/XNOR. Inverting ops (NAND/NOR/XNOR) apply a bitwise invert only at emission.
- Channel result r = base-op reduction over all NUM_IN channels.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational); beat accepted when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - out_valid stays high and out_data/out_count stay stable until transfer.
  - A new result may load in the same cycle as a transfer (full throughput).
- States:
  - IDLE, accepted beat with accum_en=0: next cycle out_valid=1, out_data=r (inverted if inverting op), out_count=1. Latency is 1 cycle. Stay in IDLE.
  - IDLE, accepted beat with accum_en=1: latch op, acc=r, cnt=1. If FRAME_LEN==1, emit as in pass mode (out_count=1) and stay IDLE; else go to ACCUM.
  - ACCUM: op and accum_en are ignored (latched values used). Each accepted beat: acc = acc base-op r, cnt=cnt+1. When cnt reaches FRAME_LEN, emit next cycle: out_data=acc (inverted if inverting op), out_count=FRAME_LEN. Clear acc/cnt, go to IDLE.
- Flush:
  - Level-sensitive; honored in ACCUM in the first cycle with in_ready=1. Emits acc with out_count=cnt, then goes to IDLE.
  - Flush in the same cycle as an accepted beat: the beat is folded in first, then emitted (out_count=cnt+1).
  - Flush coinciding with the frame-completing beat: single normal emission, out_count=FRAME_LEN.
  - Flush in IDLE: ignored.
- in_valid=1 with in_ready=0: beat not consumed; the producer must hold it.
- cnt never exceeds FRAME_LEN. out_count=0 only after reset, before the first emission.

Test Plan (WIDTH=8, NUM_IN=4, FRAME_LEN=4; channels listed ch0..ch3):
1. Pass OR: rst 2 cycles; beat {01,02,04,08}, op=001, accum_en=0, out_ready=1 -> next cycle out_valid=1, out_data=0x0F, out_count=1.
2. Pass NAND: beat {FF,FF,FF,F0}, op=011 -> out_data=0x0F, out_count=1. Reserved op=111 with {01,02,00,00} -> out_data=0x03 (OR).
3. Accumulate XOR: accum_en=1, op=010, beats {01,0,0,0},{02,0,0,0},{03,0,0,0},{04,0,0,0}; op changed to 000 after beat 1 -> single output one cycle after beat 4: out_data=0x04, out_count=4. No out_valid before that.
4. Backpressure: out_valid=1, out_ready=0 for 5 cycles -> in_ready=0, out_data constant, new in_valid beats not consumed. out_ready=1 -> transfer; a beat presented that cycle is accepted.
5. Flush: OR accumulate {10,0,0,0},{20,0,0,0}, then flush alone -> out_data=0x30, out_count=2. Repeat, with flush on the same cycle as beat {40,0,0,0} -> out_data=0x70, out_count=3.
6. Reset mid-frame: 2 beats into an OR frame, rst=1 for 1 cycle -> out_valid=0, out_data=0, out_count=0. Next frame of 4 beats {01,0,0,0} -> out_data=0x01, out_count=4 (stale beats absent).
